centroid_div_feeder: RTL and testbench

- Upstream and downstream wrapper around the pipelined divider (DIV_W-bit `a`/`b` in, `q`/`r` out, fully pipelined, one new operand pair accepted per clock).
- Counts, per video frame, the pixel coordinates of mask hits (sum_x, sum_y, count).
- At each frame boundary, issues sum_x/count and sum_y/count back-to-back into the divider.
- Captures both quotients after the fixed divider latency and presents the object centroid (cx, cy) to the tracker overlay logic.

---
 rtl/centroid_div_feeder.sv | 206 ++++++++++++++++++++
 tb/tb_centroid_div_feeder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/centroid_div_feeder.sv
// Centroid feeder: accumulates mask-hit coordinates per frame and
// streams sum/count pairs through a pipelined divider to get cx/cy.
module centroid_div_feeder #(
  parameter int DIV_W   = 32,
  parameter int COORD_W = 12,
  parameter int DIV_LAT = 34
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               de,
  input  logic               hit,
  output logic [DIV_W-1:0]   div_a,
  output logic [DIV_W-1:0]   div_b,
  input  logic [DIV_W-1:0]   div_q,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic               res_valid,
  output logic               res_found,
  output logic               res_sat,
  output logic               busy,
  output logic               drop
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE_X = 3'd1;
  localparam logic [2:0] ISSUE_Y = 3'd2;
  localparam logic [2:0] WAIT    = 3'd3;
  localparam logic [2:0] EMPTY   = 3'd4;

  localparam int WCNT_W = $clog2(DIV_LAT + 2);
  localparam logic [WCNT_W-1:0] CAP_X = WCNT_W'(DIV_LAT);
  localparam logic [WCNT_W-1:0] CAP_Y = WCNT_W'(DIV_LAT + 1);

  logic [2:0]         state;
  logic               de_d;
  logic [COORD_W-1:0] col;
  logic [COORD_W-1:0] row;

  logic [DIV_W-1:0]   sum_x;
  logic [DIV_W-1:0]   sum_y;
  logic [DIV_W-1:0]   count;
  logic               sat;

  logic [DIV_W-1:0]   sum_x_sh;
  logic [DIV_W-1:0]   sum_y_sh;
  logic [DIV_W-1:0]   count_sh;
  logic               sat_sh;
  logic               primed;

  logic [DIV_W-1:0]   sum_y_job;
  logic               sat_job;
  logic [WCNT_W-1:0]  wcnt;

  logic               pix;
  logic [DIV_W-1:0]   base_x;
  logic [DIV_W-1:0]   base_y;
  logic [DIV_W-1:0]   base_c;
  logic               base_sat;
  logic [DIV_W:0]     add_x;
  logic [DIV_W:0]     add_y;
  logic [DIV_W:0]     add_c;

  // Returns {overflow, result}; result clamps to all-ones on overflow.
  function automatic logic [DIV_W:0] sat_add(
    input logic [DIV_W-1:0] a,
    input logic [DIV_W-1:0] b
  );
    logic [DIV_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[DIV_W])
      s = {1'b1, {DIV_W{1'b1}}};
    return s;
  endfunction

  assign busy = (state != IDLE);
  assign pix  = de & hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_d <= 1'b0;
      col  <= '0;
      row  <= '0;
    end else begin
      de_d <= de;
      if (frame_start) begin
        col <= '0;
        row <= '0;
      end else if (de) begin
        col <= col + 1'b1;
      end else if (de_d) begin
        col <= '0;
        row <= row + 1'b1;
      end
    end
  end

  // A hit in the frame_start cycle lands on the freshly cleared totals.
  always_comb begin
    base_x   = frame_start ? '0 : sum_x;
    base_y   = frame_start ? '0 : sum_y;
    base_c   = frame_start ? '0 : count;
    base_sat = frame_start ? 1'b0 : sat;
    add_x    = sat_add(base_x, DIV_W'(col));
    add_y    = sat_add(base_y, DIV_W'(row));
    add_c    = sat_add(base_c, DIV_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_x <= '0;
      sum_y <= '0;
      count <= '0;
      sat   <= 1'b0;
    end else if (pix) begin
      sum_x <= add_x[DIV_W-1:0];
      sum_y <= add_y[DIV_W-1:0];
      count <= add_c[DIV_W-1:0];
      sat   <= base_sat | add_x[DIV_W]
             | add_y[DIV_W] | add_c[DIV_W];
    end else begin
      sum_x <= base_x;
      sum_y <= base_y;
      count <= base_c;
      sat   <= base_sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_x_sh <= '0;
      sum_y_sh <= '0;
      count_sh <= '0;
      sat_sh   <= 1'b0;
      primed   <= 1'b0;
    end else if (frame_start) begin
      sum_x_sh <= sum_x;
      sum_y_sh <= sum_y;
      count_sh <= count;
      sat_sh   <= sat;
      primed   <= 1'b1;
    end
  end

  // Job copies keep the in-flight result immune to a later snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div_a     <= '0;
      div_b     <= '0;
      sum_y_job <= '0;
      sat_job   <= 1'b0;
      wcnt      <= '0;
      cx        <= '0;
      cy        <= '0;
      res_valid <= 1'b0;
      res_found <= 1'b0;
      res_sat   <= 1'b0;
      drop      <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      drop      <= frame_start & busy;
      unique case (state)
        IDLE: begin
          if (frame_start && primed)
            state <= (count != '0) ? ISSUE_X : EMPTY;
        end
        ISSUE_X: begin
          div_a     <= sum_x_sh;
          div_b     <= count_sh;
          sum_y_job <= sum_y_sh;
          sat_job   <= sat_sh;
          wcnt      <= WCNT_W'(1);
          state     <= ISSUE_Y;
        end
        ISSUE_Y: begin
          div_a <= sum_y_job;
          wcnt  <= wcnt + 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          wcnt <= wcnt + 1'b1;
          if (wcnt == CAP_X)
            cx <= div_q[COORD_W-1:0];
          if (wcnt == CAP_Y) begin
            cy        <= div_q[COORD_W-1:0];
            res_valid <= 1'b1;
            res_found <= 1'b1;
            res_sat   <= sat_job;
            state     <= IDLE;
          end
        end
        EMPTY: begin
          cx        <= '0;
          cy        <= '0;
          res_found <= 1'b0;
          res_sat   <= sat_sh;
          res_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_centroid_div_feeder.sv
// Bench for centroid_div_feeder: 32-bit and 16-bit instances share
// the video stimulus; a frame model fills per-instance scoreboards.
module tb_centroid_div_feeder;

  typedef struct {
    logic [11:0] cx;
    logic [11:0] cy;
    logic        found;
    logic        sat;
    int          when;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic de = 1'b0;
  logic hit = 1'b0;

  logic [31:0] div_a32, div_b32, div_q32;
  logic [11:0] cx32, cy32;
  logic        rv32, f32, s32, busy32, drop32;
  logic [15:0] div_a16, div_b16, div_q16;
  logic [11:0] cx16, cy16;
  logic        rv16, f16, s16, busy16, drop16;

  int n_chk = 0;
  int n_fail = 0;
  int nres = 0;
  int edge_n = 0;

  exp_t sb0[$];
  exp_t sb1[$];
  longint sx[2], sy[2], cnt[2];
  bit     msat[2];
  int     idle_from[2];
  bit     exp_drop[2];
  bit     primed = 1'b0;

  bit [31:0] p32[33];
  bit [15:0] p16[17];

  centroid_div_feeder #(
    .DIV_W(32), .COORD_W(12), .DIV_LAT(34)
  ) u32 (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .de(de), .hit(hit),
    .div_a(div_a32), .div_b(div_b32), .div_q(div_q32),
    .cx(cx32), .cy(cy32), .res_valid(rv32),
    .res_found(f32), .res_sat(s32),
    .busy(busy32), .drop(drop32)
  );

  centroid_div_feeder #(
    .DIV_W(16), .COORD_W(12), .DIV_LAT(18)
  ) u16 (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .de(de), .hit(hit),
    .div_a(div_a16), .div_b(div_b16), .div_q(div_q16),
    .cx(cx16), .cy(cy16), .res_valid(rv16),
    .res_found(f16), .res_sat(s16),
    .busy(busy16), .drop(drop16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Pipelined divider models, latency matched to each DIV_LAT.
  always @(posedge clk) begin
    p32[0] <= (div_b32 == 0) ? '1 : div_a32 / div_b32;
    for (int k = 1; k < 33; k++) p32[k] <= p32[k-1];
    p16[0] <= (div_b16 == 0) ? '1 : div_a16 / div_b16;
    for (int k = 1; k < 17; k++) p16[k] <= p16[k-1];
  end
  assign div_q32 = p32[32];
  assign div_q16 = p16[16];

  function automatic int dw(input int i);
    return (i == 0) ? 32 : 16;
  endfunction

  function automatic int lat(input int i);
    return (i == 0) ? 34 : 18;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic mon(input int i,
                     input logic [11:0] c_x,
                     input logic [11:0] c_y,
                     input logic f, input logic s);
    exp_t e;
    bit empty;
    nres++;
    empty = (i == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
    if (empty) begin
      chk($sformatf("res_unexpected%0d", dw(i)), 1, 0);
    end else begin
      e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
      chk($sformatf("cx%0d", dw(i)), c_x, e.cx);
      chk($sformatf("cy%0d", dw(i)), c_y, e.cy);
      chk($sformatf("found%0d", dw(i)), f, e.found);
      chk($sformatf("sat%0d", dw(i)), s, e.sat);
      chk($sformatf("when%0d", dw(i)), edge_n, e.when);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rv32) mon(0, cx32, cy32, f32, s32);
    if (!rst && rv16) mon(1, cx16, cy16, f16, s16);
  end

  task automatic pix(input int x, input int y, input bit h);
    longint lim;
    @(negedge clk);
    de = 1'b1;
    hit = h;
    if (h) begin
      for (int i = 0; i < 2; i++) begin
        lim = (64'd1 << dw(i)) - 1;
        sx[i] += x;
        sy[i] += y;
        cnt[i] += 1;
        if (sx[i] > lim) begin sx[i] = lim; msat[i] = 1'b1; end
        if (sy[i] > lim) begin sy[i] = lim; msat[i] = 1'b1; end
        if (cnt[i] > lim) begin cnt[i] = lim; msat[i] = 1'b1; end
      end
    end
  endtask

  // mode 0: hits at (2,1),(4,3); mode 1: none; mode 2: all
  task automatic frame(input int w, input int h, input int mode);
    bit hh;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        hh = (mode == 2) ||
             (mode == 0 && ((x == 2 && y == 1) || (x == 4 && y == 3)));
        pix(x, y, hh);
      end
      @(negedge clk);
      de = 1'b0;
      hit = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic fs();
    exp_t e;
    int ev;
    @(negedge clk);
    frame_start = 1'b1;
    de = 1'b0;
    hit = 1'b0;
    ev = edge_n + 1;
    for (int i = 0; i < 2; i++) begin
      exp_drop[i] = 1'b0;
      if (primed) begin
        if (ev >= idle_from[i]) begin
          e.found = (cnt[i] != 0);
          e.sat = msat[i];
          if (cnt[i] != 0) begin
            e.cx = 12'(sx[i] / cnt[i]);
            e.cy = 12'(sy[i] / cnt[i]);
            e.when = ev + lat(i) + 2;
            idle_from[i] = ev + lat(i) + 3;
          end else begin
            e.cx = '0;
            e.cy = '0;
            e.when = ev + 1;
            idle_from[i] = ev + 2;
          end
          if (i == 0) sb0.push_back(e);
          else sb1.push_back(e);
        end else begin
          exp_drop[i] = 1'b1;
        end
      end
      sx[i] = 0;
      sy[i] = 0;
      cnt[i] = 0;
      msat[i] = 1'b0;
    end
    primed = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("drop32", drop32, exp_drop[0]);
    chk("drop16", drop16, exp_drop[1]);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300 && (sb0.size() + sb1.size()) != 0; k++)
      @(negedge clk);
    chk("drain_timeout", sb0.size() + sb1.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out32"},
        {cx32, cy32, rv32, f32, s32, busy32, drop32}, 0);
    chk({tag, "_div32"}, {div_a32, div_b32}, 0);
    chk({tag, "_out16"},
        {cx16, cy16, rv16, f16, s16, busy16, drop16}, 0);
    chk({tag, "_div16"}, {div_a16, div_b16}, 0);
  endtask

  task automatic model_reset();
    sb0.delete();
    sb1.delete();
    primed = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sx[i] = 0;
      sy[i] = 0;
      cnt[i] = 0;
      msat[i] = 1'b0;
      idle_from[i] = 0;
    end
  endtask

  int base;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // first frame_start after reset: no result
    fs();
    repeat (5) @(negedge clk);
    chk("first_fs_nores", nres, 0);
    chk_zero("first_fs");

    // 8x4 frame with two hits, operand issue order
    frame(8, 4, 0);
    fs();
    @(negedge clk);
    chk("issue_x_a32", div_a32, 6);
    chk("issue_x_b32", div_b32, 2);
    chk("issue_x_a16", div_a16, 6);
    @(negedge clk);
    chk("issue_y_a32", div_a32, 4);
    chk("issue_y_b32", div_b32, 2);
    chk("issue_y_b16", div_b16, 2);
    chk("busy_wait32", busy32, 1);
    wait_idle();

    // empty frame
    frame(8, 4, 1);
    fs();
    wait_idle();
    chk("busy_after_empty", {busy32, busy16}, 0);

    // frame_start while the divider job is in flight
    frame(8, 4, 0);
    fs();
    repeat (10) @(negedge clk);
    frame(3, 1, 2);
    fs();
    frame(8, 4, 0);
    wait_idle();
    fs();
    wait_idle();

    // 4096-wide full line: 16-bit sum_x saturates
    frame(4096, 1, 2);
    fs();
    wait_idle();

    // reset in the middle of WAIT
    frame(8, 4, 0);
    fs();
    repeat (5) @(negedge clk);
    chk("busy_pre_rst", {busy32, busy16}, 2'b11);
    rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    base = nres;
    repeat (60) @(negedge clk);
    fs();
    repeat (60) @(negedge clk);
    chk("post_rst_nores", nres, base);
    chk("post_rst_busy", {busy32, busy16}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
